// File: rtl/my_rx_uart_ng.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample mid-bit majority vote,
// break detection, one-entry valid/ready holding register. Parity bit enabled by RX_PARITY_EN.
module my_rx_uart_ng #(
  parameter int SYSTEM_CLK_MHZ = 25,
  parameter int BAUDRATE       = 9600,
  parameter int DATA_BITS      = 8,
  parameter int STOP_BITS      = 1,
  parameter int PARITY_ODD     = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx_in,
  input  logic                 rx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int CPB = (SYSTEM_CLK_MHZ * 1000000) / BAUDRATE;
  localparam int MID = CPB >> 1;
  localparam int CW  = $clog2(CPB);
  localparam int IW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] C_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] C_S1   = CW'(MID);
  localparam logic [CW-1:0] C_DEC  = CW'(MID + 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
  localparam logic          TWO_STOP = (STOP_BITS == 2);

  if (CPB < 4 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_err
    $error("my_rx_uart_ng: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef RX_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_t;

  state_t                r_state, w_next;
  logic [1:0]            r_sync;
  logic                  r_rx_prev;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_bit_idx;
  logic                  r_stop_idx;
  logic [1:0]            r_smp;
  logic [DATA_BITS-1:0]  r_shadow;
  logic                  r_stop_bad;
  logic                  r_allz;
  logic                  w_rx_s, w_fall, w_maj, w_dec, w_bit_end;
  logic                  w_last_stop, w_done, w_stop_bad_f, w_allz_f, w_load, w_par_err;

  assign w_rx_s    = r_sync[1];
  assign w_fall    = r_rx_prev & ~w_rx_s;
  // Third vote is the live synchronised sample at the decision count.
  assign w_maj     = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rx_s) | (r_smp[1] & w_rx_s);
  assign w_dec     = (r_cnt == C_DEC);
  assign w_bit_end = (r_cnt == C_LAST);

  assign w_last_stop  = ~TWO_STOP | r_stop_idx;
  assign w_done       = (r_state == S_STOP) & w_dec & w_last_stop;
  assign w_stop_bad_f = r_stop_bad | ~w_maj;
  assign w_allz_f     = r_allz & ~w_maj;
  assign w_load       = w_done & ~w_stop_bad_f & (~rx_valid | rx_ready);

`ifdef RX_PARITY_EN
  logic r_par;
  assign w_par_err = r_par ^ (PARITY_ODD == 1);
`else
  assign w_par_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_fall) w_next = S_START;
      S_START: begin
        if (w_dec && w_maj) w_next = S_IDLE;
        else if (w_bit_end) w_next = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end && r_bit_idx == I_LAST) begin
`ifdef RX_PARITY_EN
          w_next = S_PAR;
`else
          w_next = S_STOP;
`endif
        end
      end
`ifdef RX_PARITY_EN
      S_PAR:   if (w_bit_end) w_next = S_STOP;
`endif
      S_STOP:  if (w_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync     <= 2'b11;
      r_rx_prev  <= 1'b1;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_smp      <= '0;
      r_shadow   <= '0;
      r_stop_bad <= 1'b0;
      r_allz     <= 1'b0;
`ifdef RX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_sync    <= {r_sync[0], rx_in};
      r_rx_prev <= w_rx_s;
      if (r_state == S_IDLE) begin
        r_cnt      <= '0;
        r_bit_idx  <= '0;
        r_stop_idx <= 1'b0;
        r_stop_bad <= 1'b0;
        r_allz     <= 1'b1;
`ifdef RX_PARITY_EN
        r_par      <= 1'b0;
`endif
      end else begin
        r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
        if (r_cnt == C_S0) r_smp[0] <= w_rx_s;
        if (r_cnt == C_S1) r_smp[1] <= w_rx_s;
        if (w_dec) begin
          case (r_state)
            S_DATA: begin
              r_shadow[r_bit_idx] <= w_maj;
              r_allz              <= r_allz & ~w_maj;
`ifdef RX_PARITY_EN
              r_par               <= r_par ^ w_maj;
`endif
            end
`ifdef RX_PARITY_EN
            S_PAR: begin
              r_allz <= r_allz & ~w_maj;
              r_par  <= r_par ^ w_maj;
            end
`endif
            S_STOP: begin
              r_stop_bad <= r_stop_bad | ~w_maj;
              r_allz     <= r_allz & ~w_maj;
            end
            default: ;
          endcase
        end
        if (w_bit_end) begin
          if (r_state == S_DATA) r_bit_idx  <= r_bit_idx + 1'b1;
          if (r_state == S_STOP) r_stop_idx <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
      break_det   <= 1'b0;
      if (w_done) begin
        if (w_stop_bad_f) begin
          frame_err <= 1'b1;
          break_det <= w_allz_f;
        end else if (!rx_valid || rx_ready) begin
          parity_err <= w_par_err;
        end else begin
          overrun_err <= 1'b1;
        end
      end
      if (w_load) begin
        rx_valid <= 1'b1;
        rx_data  <= r_shadow;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_my_rx_uart_ng.sv
// Directed bench for my_rx_uart_ng: 8-bit/1-stop instance plus a 5-bit/2-stop instance,
// both at 10 clocks per bit.
module tb_my_rx_uart_ng;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx_a, rx_b, ready_a, ready_b;
  logic       valid_a, fe_a, pe_a, ov_a, bk_a, busy_a;
  logic [7:0] data_a;
  logic       valid_b, fe_b, pe_b, ov_b, bk_b, busy_b;
  logic [4:0] data_b;

  int n_total = 0, n_pass = 0, n_fail = 0;
  int n_vcyc = 0, n_fe = 0, n_pe = 0, n_ov = 0, n_bk = 0, n_bf = 0, n_busy = 0;
  int n_vb = 0, n_feb = 0, n_other_b = 0;
  logic [7:0] last_a = '0;
  logic [4:0] last_b = '0;
  int s_vcyc, s_fe, s_pe, s_ov, s_bk, s_bf, s_busy, s_vb, s_feb;
  int exp_pe_total;

  always #5 clk = ~clk;

  my_rx_uart_ng #(.SYSTEM_CLK_MHZ(1), .BAUDRATE(100000), .DATA_BITS(8), .STOP_BITS(1),
                  .PARITY_ODD(0)) u_dut (
    .clk(clk), .resetn(resetn), .rx_in(rx_a), .rx_ready(ready_a), .rx_valid(valid_a),
    .rx_data(data_a), .frame_err(fe_a), .parity_err(pe_a), .overrun_err(ov_a),
    .break_det(bk_a), .busy(busy_a));

  my_rx_uart_ng #(.SYSTEM_CLK_MHZ(1), .BAUDRATE(100000), .DATA_BITS(5), .STOP_BITS(2),
                  .PARITY_ODD(0)) u_dut5 (
    .clk(clk), .resetn(resetn), .rx_in(rx_b), .rx_ready(ready_b), .rx_valid(valid_b),
    .rx_data(data_b), .frame_err(fe_b), .parity_err(pe_b), .overrun_err(ov_b),
    .break_det(bk_b), .busy(busy_b));

  always @(negedge clk) begin
    if (resetn) begin
      if (valid_a) begin n_vcyc++; last_a = data_a; end
      if (fe_a) n_fe++;
      if (pe_a) n_pe++;
      if (ov_a) n_ov++;
      if (bk_a) n_bk++;
      if (bk_a && fe_a) n_bf++;
      if (busy_a) n_busy++;
      if (valid_b) begin n_vb++; last_b = data_b; end
      if (fe_b) n_feb++;
      if (pe_b || ov_b || bk_b) n_other_b++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_vcyc = n_vcyc; s_fe = n_fe; s_pe = n_pe; s_ov = n_ov; s_bk = n_bk; s_bf = n_bf;
    s_busy = n_busy; s_vb = n_vb; s_feb = n_feb;
  endtask

  task automatic send_bits(input logic to_b, input logic [15:0] bits, input int len);
    for (int i = 0; i < len; i++) begin
      if (to_b) rx_b = bits[i];
      else      rx_a = bits[i];
      wait_cyc(CPB);
    end
    rx_a = 1'b1;
    rx_b = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stopv);
    logic [15:0] b;
`ifdef RX_PARITY_EN
    b = {5'b11111, stopv, (^d) ^ pflip, d, 1'b0};
    send_bits(1'b0, b, 11);
`else
    b = {6'b111111, stopv, d, 1'b0};
    send_bits(1'b0, b, 10);
`endif
  endtask

  initial begin
    resetn = 1'b0; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
`ifdef RX_PARITY_EN
    exp_pe_total = 1;
`else
    exp_pe_total = 0;
`endif
    wait_cyc(3);
    check("reset_valid", valid_a, 0);
    check("reset_data", data_a, 0);
    check("reset_flags", {fe_a, pe_a, ov_a, bk_a}, 0);
    check("reset_busy", busy_a, 0);
    resetn = 1'b1;
    wait_cyc(10);

    // 1: clean 0xA5 with consumer ready
    snap();
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_cyc(20);
    check("a5_valid_cycles", n_vcyc - s_vcyc, 1);
    check("a5_data", last_a, 8'hA5);
    check("a5_no_flags", (n_fe - s_fe) + (n_ov - s_ov) + (n_bk - s_bk) + (n_pe - s_pe), 0);

    // 2: holding register full -> overrun
    ready_a = 1'b0;
    snap();
    send_frame(8'h3C, 1'b0, 1'b1);
    wait_cyc(20);
    check("hold_valid", valid_a, 1);
    check("hold_data", data_a, 8'h3C);
    send_frame(8'h81, 1'b0, 1'b1);
    wait_cyc(20);
    check("overrun_pulses", n_ov - s_ov, 1);
    check("overrun_data_kept", data_a, 8'h3C);
    check("overrun_valid_kept", valid_a, 1);
    ready_a = 1'b1;
    wait_cyc(1);
    check("drain_valid_low", valid_a, 0);

    // 3: false start, then glitch inside data bit 1 of 0x55
    snap();
    rx_a = 1'b0; wait_cyc(3);
    rx_a = 1'b1; wait_cyc(30);
    check("false_start_busy_seen", (n_busy - s_busy) > 0, 1);
    check("false_start_idle", busy_a, 0);
    check("false_start_quiet", (n_vcyc - s_vcyc) + (n_fe - s_fe) + (n_bk - s_bk), 0);
    snap();
    rx_a = 1'b0; wait_cyc(CPB);
    rx_a = 1'b1; wait_cyc(CPB);
    rx_a = 1'b0; wait_cyc(5);
    rx_a = 1'b1; wait_cyc(1);
    rx_a = 1'b0; wait_cyc(4);
`ifdef RX_PARITY_EN
    send_bits(1'b0, {8'hFF, 1'b1, 1'b0, 6'b010101}, 8);
`else
    send_bits(1'b0, {9'h1FF, 1'b1, 6'b010101}, 7);
`endif
    wait_cyc(20);
    check("glitch_valid", n_vcyc - s_vcyc, 1);
    check("glitch_data", last_a, 8'h55);

    // 4: stop bit low, then a long break
    snap();
    send_frame(8'h7E, 1'b0, 1'b0);
    wait_cyc(30);
    check("stop0_frame_err", n_fe - s_fe, 1);
    check("stop0_no_valid", n_vcyc - s_vcyc, 0);
    check("stop0_no_break", n_bk - s_bk, 0);
    snap();
    rx_a = 1'b0; wait_cyc(12 * CPB);
    check("break_det", n_bk - s_bk, 1);
    check("break_with_frame", n_bf - s_bf, 1);
    check("break_idle_low", busy_a, 0);
    rx_a = 1'b1; wait_cyc(30);
    check("break_release_quiet", (n_fe - s_fe) + (n_vcyc - s_vcyc) + busy_a, 1);

`ifdef RX_PARITY_EN
    // 5: parity
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    wait_cyc(20);
    check("par_bad_flag", n_pe - s_pe, 1);
    check("par_bad_data", last_a, 8'h07);
    snap();
    send_frame(8'h07, 1'b0, 1'b1);
    wait_cyc(20);
    check("par_ok_flag", n_pe - s_pe, 0);
    check("par_ok_valid", n_vcyc - s_vcyc, 1);
`endif

    // 6: reset mid-DATA, then a clean frame
    rx_a = 1'b0; wait_cyc(3 * CPB);
    check("mid_frame_busy", busy_a, 1);
    resetn = 1'b0; rx_a = 1'b1;
    #1;
    check("async_reset_busy", busy_a, 0);
    check("async_reset_data", data_a, 0);
    check("async_reset_valid", valid_a, 0);
    wait_cyc(3);
    resetn = 1'b1;
    wait_cyc(20);
    snap();
    send_frame(8'h12, 1'b0, 1'b1);
    wait_cyc(20);
    check("post_reset_data", last_a, 8'h12);
    check("post_reset_valid", n_vcyc - s_vcyc, 1);
    check("post_reset_no_fe", n_fe - s_fe, 0);

    // 5-bit, 2-stop instance
    snap();
`ifdef RX_PARITY_EN
    send_bits(1'b1, {7'h7F, 1'b1, 1'b1, 1'b1, 5'h15, 1'b0}, 9);
`else
    send_bits(1'b1, {8'hFF, 1'b1, 1'b1, 5'h15, 1'b0}, 8);
`endif
    wait_cyc(20);
    check("d5_data", last_b, 5'h15);
    check("d5_valid", n_vb - s_vb, 1);
    check("d5_no_fe", n_feb - s_feb, 0);
    snap();
`ifdef RX_PARITY_EN
    send_bits(1'b1, {7'h7F, 1'b0, 1'b1, 1'b1, 5'h15, 1'b0}, 9);
`else
    send_bits(1'b1, {8'hFF, 1'b0, 1'b1, 5'h15, 1'b0}, 8);
`endif
    wait_cyc(20);
    check("d5_stop2_frame_err", n_feb - s_feb, 1);
    check("d5_stop2_no_valid", n_vb - s_vb, 0);
    check("d5_idle", busy_b, 0);
    check("d5_other_flags", n_other_b, 0);

    check("parity_err_total", n_pe, exp_pe_total);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
